// File: rtl/fir_pkg.sv
// fir_pkg: shared state type and arithmetic helpers
// for the multi-channel FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_e;

  function automatic int acc_width(
    input int dw,
    input int cw,
    input int ntaps
  );
    return dw + cw + $clog2(ntaps);
  endfunction

  // Round half up, then clamp to the signed dw-bit range.
  function automatic logic signed [63:0] sat_round(
    input logic signed [63:0] acc,
    input int                 shift,
    input int                 dw
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (shift > 0) begin
      r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    end
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_filter_mc_coef_bank.sv
// fir_coef_bank: shadow/active coefficient banks with
// glitch-free commit, deferred while a sample is in flight.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int  CW    = 16,
  parameter int  NTAPS = 32,
  localparam int TW    = $clog2(NTAPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 h_write,
  input  logic [TW-1:0]        h_idx,
  input  logic [CW-1:0]        h_data,
  input  logic                 h_commit,
  input  logic                 is_idle,
  input  logic                 enter_idle,
  input  logic [TW-1:0]        rd_idx,
  output logic signed [CW-1:0] rd_data
);

  logic signed [CW-1:0] shadow_q [NTAPS];
  logic signed [CW-1:0] shadow_d [NTAPS];
  logic signed [CW-1:0] act_q [NTAPS];
  logic signed [CW-1:0] act_d [NTAPS];
  logic                 pend_q;
  logic                 pend_d;
  logic                 apply;

  // The copy source is shadow_d so a same-cycle write is included.
  always_comb begin
    shadow_d = shadow_q;
    if (h_write) begin
      shadow_d[h_idx] = h_data;
    end
    apply = (h_commit && is_idle) ||
            ((h_commit || pend_q) && enter_idle);
    pend_d = pend_q;
    if (apply) begin
      pend_d = 1'b0;
    end else if (h_commit) begin
      pend_d = 1'b1;
    end
    act_d = act_q;
    if (apply) begin
      act_d = shadow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '{default: '0};
      act_q    <= '{default: '0};
      pend_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
    end
  end

  assign rd_data = act_q[rd_idx];

endmodule

// File: rtl/fir_filter_mc.sv
// fir_filter_mc: multi-channel FIR, channels time-shared
// over one multiply-accumulate unit, one tap per cycle.
module fir_filter_mc
  import fir_pkg::*;
#(
  parameter int  DW    = 16,
  parameter int  CW    = 16,
  parameter int  NTAPS = 32,
  parameter int  NCH   = 2,
  parameter int  SHIFT = 15,
  localparam int ACCW  = acc_width(DW, CW, NTAPS),
  localparam int TW    = $clog2(NTAPS),
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_data,
  input  logic           h_write,
  input  logic [TW-1:0]  h_idx,
  input  logic [CW-1:0]  h_data,
  input  logic           h_commit,
  output logic           ch_err
);

  state_e                 state_q;
  state_e                 state_d;
  logic [CHW-1:0]         ch_q;
  logic [CHW-1:0]         ch_d;
  logic [TW-1:0]          k_q;
  logic [TW-1:0]          k_d;
  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_d;
  logic [TW-1:0]          wp_q [NCH];
  logic [TW-1:0]          wp_d [NCH];
  logic signed [DW-1:0]   dl_q [NCH][NTAPS];
  logic signed [DW-1:0]   dl_d [NCH][NTAPS];
  logic                   in_ready_q;
  logic                   in_ready_d;
  logic                   out_valid_q;
  logic                   out_valid_d;
  logic [CHW-1:0]         out_ch_q;
  logic [CHW-1:0]         out_ch_d;
  logic [DW-1:0]          out_data_q;
  logic [DW-1:0]          out_data_d;
  logic                   ch_err_q;
  logic                   ch_err_d;

  logic                     fire;
  logic                     legal;
  logic                     is_idle;
  logic                     enter_idle;
  logic [TW-1:0]            tap_idx;
  logic signed [DW-1:0]     tap_x;
  logic signed [CW-1:0]     coef;
  logic signed [DW+CW-1:0]  prod;
  logic signed [ACCW-1:0]   prod_ext;
  logic signed [63:0]       acc_ext;

  assign is_idle    = (state_q == IDLE);
  assign enter_idle = (state_q == OUT) && out_ready;
  assign fire       = in_valid && in_ready_q && is_idle;
  assign legal      = int'(in_ch) < NCH;

  // Tap k reads the sample k positions behind the newest one.
  assign tap_idx  = wp_q[ch_q] - k_q;
  assign tap_x    = dl_q[ch_q][tap_idx];
  assign prod     = coef * tap_x;
  assign prod_ext = {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};
  assign acc_ext  = {{(64-ACCW){acc_q[ACCW-1]}}, acc_q};

  fir_coef_bank #(
    .CW    (CW),
    .NTAPS (NTAPS)
  ) u_coef (
    .clk        (clk),
    .reset      (reset),
    .h_write    (h_write),
    .h_idx      (h_idx),
    .h_data     (h_data),
    .h_commit   (h_commit),
    .is_idle    (is_idle),
    .enter_idle (enter_idle),
    .rd_idx     (k_q),
    .rd_data    (coef)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    k_d         = k_q;
    acc_d       = acc_q;
    wp_d        = wp_q;
    dl_d        = dl_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    ch_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (legal) begin
            dl_d[in_ch][wp_q[in_ch]] = in_data;
            ch_d    = in_ch;
            k_d     = '0;
            acc_d   = '0;
            state_d = MAC;
          end else begin
            ch_err_d = 1'b1;
          end
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + 1'b1;
        if (k_q == TW'(NTAPS - 1)) begin
          wp_d[ch_q] = wp_q[ch_q] + 1'b1;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        out_data_d  = DW'(sat_round(acc_ext, SHIFT, DW));
        out_ch_d    = ch_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      wp_q        <= '{default: '0};
      dl_q        <= '{default: '0};
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      ch_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      wp_q        <= wp_d;
      dl_q        <= dl_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      ch_err_q    <= ch_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign ch_err    = ch_err_q;

endmodule

// File: tb/tb_fir_filter_mc.sv
// tb_fir_filter_mc: scoreboard bench for fir_filter_mc,
// expected outputs from a direct-form reference model.
module tb_fir_filter_mc;

  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int NTAPS = 32;
  localparam int NCH   = 3;
  localparam int SHIFT = 15;
  localparam int TW    = 5;
  localparam int CHW   = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [CHW-1:0] in_ch = '0;
  logic [DW-1:0]  in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [CHW-1:0] out_ch;
  logic [DW-1:0]  out_data;
  logic           h_write = 1'b0;
  logic [TW-1:0]  h_idx = '0;
  logic [CW-1:0]  h_data = '0;
  logic           h_commit = 1'b0;
  logic           ch_err;

  fir_filter_mc #(
    .DW    (DW),
    .CW    (CW),
    .NTAPS (NTAPS),
    .NCH   (NCH),
    .SHIFT (SHIFT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .h_write   (h_write),
    .h_idx     (h_idx),
    .h_data    (h_data),
    .h_commit  (h_commit),
    .ch_err    (ch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   h_sh [NTAPS];
  int   h_act [NTAPS];
  int   hist [NCH][NTAPS];
  int   cyc = 0;
  int   acc_cyc = 0;
  int   err_pulses = 0;
  int   ov_cycles = 0;
  logic prev_ov = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int model_out(input int ch);
    longint s;
    s = 0;
    for (int k = 0; k < NTAPS; k++) begin
      s += longint'(h_act[k]) * longint'(hist[ch][k]);
    end
    s = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < NTAPS; k++) begin
      h_sh[k]  = 0;
      h_act[k] = 0;
      for (int c = 0; c < NCH; c++) hist[c][k] = 0;
    end
  endtask

  task automatic push_sample(input int ch, input int d);
    exp_t e;
    for (int k = NTAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = d;
    e.ch   = ch;
    e.data = model_out(ch);
    exp_q.push_back(e);
  endtask

  task automatic write_coef(input int idx, input int val);
    h_write = 1'b1;
    h_idx   = TW'(idx);
    h_data  = CW'(val);
    h_sh[idx] = s16(CW'(val));
    @(negedge clk);
    h_write = 1'b0;
  endtask

  task automatic commit_idle();
    h_commit = 1'b1;
    h_act    = h_sh;
    @(negedge clk);
    h_commit = 1'b0;
  endtask

  task automatic send(input int ch, input int d, input bit cm = 1'b0);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_ready", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    in_ch    = CHW'(ch);
    in_data  = DW'(d);
    if (cm) begin
      h_commit = 1'b1;
      h_act    = h_sh;
    end
    acc_cyc = cyc + 1;
    if (ch < NCH) push_sample(ch, s16(DW'(d)));
    @(negedge clk);
    in_valid = 1'b0;
    h_commit = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    commit_idle();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (out_valid && !prev_ov) check("latency", cyc - acc_cyc, NTAPS + 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexp_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", $signed(out_data), mon_e.data);
          check("out_ch", out_ch, mon_e.ch);
        end
      end
      if (ch_err) err_pulses++;
      if (out_valid) ov_cycles++;
    end
    prev_ov = out_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hold_d;
    int hold_ch;
    int n;
    int e0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_ch_err", ch_err, 0);
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);

    load_ramp();
    send(0, 16'h7FFF);
    for (int i = 0; i < 40; i++) send(0, 0);
    drain();

    send(0, 16'h7FFF);
    send(1, 0);
    for (int i = 0; i < 33; i++) begin
      send(0, 0);
      send(1, 0);
    end
    drain();

    out_ready = 1'b0;
    send(1, 16'h0400);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", out_valid, 1);
    hold_d  = out_data;
    hold_ch = out_ch;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_ch    = 2'd2;
      in_data  = 16'h3333;
      @(negedge clk);
      check("bp_valid_hold", out_valid, 1);
      check("bp_data_hold", out_data, hold_d);
      check("bp_ch_hold", out_ch, hold_ch);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    for (int k = 0; k < NTAPS; k++) write_coef(k, 16'h7FFF);
    commit_idle();
    for (int i = 0; i < 32; i++) send(2, 16'h7FFF);
    for (int i = 0; i < 32; i++) send(2, 16'h8000);
    drain();

    load_ramp();
    send(0, 16'h7FFF);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    reset = 1'b0;
    ov_cycles = 0;
    @(negedge clk);
    check("mid_rst_ready_up", in_ready, 1);
    repeat (40) @(negedge clk);
    check("mid_rst_no_out", ov_cycles, 0);

    write_coef(0, 16'h7FFF);
    send(0, 16'h1234);
    repeat (5) @(negedge clk);
    h_commit = 1'b1;
    @(negedge clk);
    h_commit = 1'b0;
    drain();
    h_act = h_sh;
    send(0, 16'h1234);
    drain();

    write_coef(0, 16'h4000);
    h_write = 1'b1;
    h_idx   = TW'(1);
    h_data  = 16'h7FFF;
    h_sh[1] = 32767;
    send(0, 16'h0100, 1'b1);
    h_write = 1'b0;
    drain();

    load_ramp();
    send(2, 16'h7FFF);
    for (int i = 0; i < 33; i++) send(2, 0);
    drain();

    e0 = err_pulses;
    ov_cycles = 0;
    in_valid = 1'b1;
    in_ch    = 2'd3;
    in_data  = 16'h5555;
    @(negedge clk);
    in_valid = 1'b0;
    check("ch_err_pulse", ch_err, 1);
    @(negedge clk);
    check("ch_err_clear", ch_err, 0);
    check("ch_err_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    check("ch_err_count", err_pulses - e0, 1);
    check("ch_err_no_out", ov_cycles, 0);
    check("ch_err_total", err_pulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
